// File: rtl/uart_if.sv
// uart_if: serial link and host-side handshake signals of one UART transceiver
interface uart_if;
  logic [2:0] baud_rate_select;
  logic [7:0] Tx_Byte;
  logic       Tx_Enable;
  logic       Tx_Serial;
  logic       Tx_Done;
  logic       Tx_Active;
  logic       RX_Enable;
  logic       RX_Data;
  logic [7:0] Rx_Byte;
  modport master (
    output baud_rate_select, Tx_Byte, Tx_Enable, RX_Enable, RX_Data,
    input  Tx_Serial, Tx_Done, Tx_Active, Rx_Byte
  );
  modport slave (
    input  baud_rate_select, Tx_Byte, Tx_Enable, RX_Enable, RX_Data,
    output Tx_Serial, Tx_Done, Tx_Active, Rx_Byte
  );
endinterface

// File: rtl/uart_top.sv
// uart_top: full-duplex 8N1 UART transceiver with selectable baud rate
module uart_top #(
  parameter int CLK_FREQ = 50_000_000
) (
  input logic   internal_clock,
  input logic   rst_n,
  uart_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [15:0] DIVS [8] = '{
    16'((CLK_FREQ + 57600) / 115200), 16'((CLK_FREQ + 28800) / 57600),
    16'((CLK_FREQ + 19200) / 38400),  16'((CLK_FREQ + 9600) / 19200),
    16'((CLK_FREQ + 4800) / 9600),    16'((CLK_FREQ + 2400) / 4800),
    16'((CLK_FREQ + 1200) / 2400),    16'((CLK_FREQ + 600) / 1200)
  };
  state_t      tx_state, tx_state_n, rx_state, rx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n, rx_cnt, rx_cnt_n, rx_div, rx_div_n;
  logic [7:0]  tx_sh, tx_sh_n, rx_sh, rx_sh_n, rx_byte, rx_byte_n;
  logic [2:0]  tx_idx, tx_idx_n, rx_idx, rx_idx_n;
  logic        tx_ser, tx_ser_n, tx_act, tx_act_n, tx_done, tx_done_n;
  logic        rx_s1, rx_s2, rx_s3, tx_wrap, rx_wrap;
  assign tx_wrap       = tx_cnt == tx_div - 16'd1;
  assign rx_wrap       = rx_cnt == rx_div - 16'd1;
  assign bus.Tx_Serial = tx_ser;
  assign bus.Tx_Active = tx_act;
  assign bus.Tx_Done   = tx_done;
  assign bus.Rx_Byte   = rx_byte;
  // TX state and registered line outputs; the line itself never comes from logic
  always_ff @(posedge internal_clock or negedge rst_n)
    if (!rst_n) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_sh    <= '0;
      tx_idx   <= '0;
      tx_ser   <= 1'b1;
      tx_act   <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_div   <= tx_div_n;
      tx_sh    <= tx_sh_n;
      tx_idx   <= tx_idx_n;
      tx_ser   <= tx_ser_n;
      tx_act   <= tx_act_n;
      tx_done  <= tx_done_n;
    end
  // TX next state: the done cycle doubles as the idle slot that can restart a frame
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 16'd1;
    tx_div_n   = tx_div;
    tx_sh_n    = tx_sh;
    tx_idx_n   = tx_idx;
    tx_ser_n   = tx_ser;
    tx_act_n   = tx_act;
    tx_done_n  = 1'b0;
    unique case (tx_state)
      IDLE: begin
        tx_cnt_n = '0;
        tx_idx_n = '0;
        if (!bus.Tx_Enable) begin
          tx_state_n = START;
          tx_div_n   = DIVS[bus.baud_rate_select];
          tx_sh_n    = bus.Tx_Byte;
          tx_ser_n   = 1'b0;
          tx_act_n   = 1'b1;
        end
      end
      START: if (tx_wrap) begin
        tx_state_n = DATA;
        tx_cnt_n   = '0;
        tx_ser_n   = tx_sh[0];
      end
      DATA: if (tx_wrap) begin
        tx_state_n = tx_idx == 3'd7 ? STOP : DATA;
        tx_cnt_n   = '0;
        tx_sh_n    = tx_sh >> 1;
        tx_idx_n   = tx_idx + 3'd1;
        tx_ser_n   = tx_idx == 3'd7 ? 1'b1 : tx_sh[1];
      end
      STOP: if (tx_wrap) begin
        tx_state_n = IDLE;
        tx_cnt_n   = '0;
        tx_act_n   = 1'b0;
        tx_done_n  = 1'b1;
      end
    endcase
  end
  // RX synchronizer plus one extra stage for falling-edge detection
  always_ff @(posedge internal_clock or negedge rst_n)
    if (!rst_n) {rx_s3, rx_s2, rx_s1} <= 3'b111;
    else {rx_s3, rx_s2, rx_s1} <= {rx_s2, rx_s1, bus.RX_Data};
  // RX state and received byte
  always_ff @(posedge internal_clock or negedge rst_n)
    if (!rst_n) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_sh    <= '0;
      rx_idx   <= '0;
      rx_byte  <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_div   <= rx_div_n;
      rx_sh    <= rx_sh_n;
      rx_idx   <= rx_idx_n;
      rx_byte  <= rx_byte_n;
    end
  // RX next state: half-bit start check, then one sample per bit centre
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 16'd1;
    rx_div_n   = rx_div;
    rx_sh_n    = rx_sh;
    rx_idx_n   = rx_idx;
    rx_byte_n  = rx_byte;
    if (bus.RX_Enable) begin
      rx_state_n = IDLE;
      rx_cnt_n   = '0;
    end else unique case (rx_state)
      IDLE: begin
        rx_cnt_n = '0;
        rx_idx_n = '0;
        if (rx_s3 && !rx_s2) begin
          rx_state_n = START;
          rx_div_n   = DIVS[bus.baud_rate_select];
        end
      end
      START: if (rx_cnt == rx_div >> 1) begin
        rx_state_n = rx_s2 ? IDLE : DATA;
        rx_cnt_n   = '0;
      end
      DATA: if (rx_wrap) begin
        rx_state_n = rx_idx == 3'd7 ? STOP : DATA;
        rx_cnt_n   = '0;
        rx_sh_n    = {rx_s2, rx_sh[7:1]};
        rx_idx_n   = rx_idx + 3'd1;
      end
      STOP: if (rx_wrap) begin
        rx_state_n = IDLE;
        rx_cnt_n   = '0;
        rx_byte_n  = rx_s2 ? rx_sh : rx_byte;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: two cross-wired transceivers exercised with directed frames
module tb_uart_top;
  logic internal_clock = 1'b0;
  logic rst_n;
  logic b_inj, b_drv;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  uart_if ia();
  uart_if ib();
  assign ia.RX_Data = ib.Tx_Serial;
  assign ib.RX_Data = b_inj ? b_drv : ia.Tx_Serial;
  uart_top #(.CLK_FREQ(50_000_000)) dut_a (.internal_clock(internal_clock), .rst_n(rst_n), .bus(ia));
  uart_top #(.CLK_FREQ(50_000_000)) dut_b (.internal_clock(internal_clock), .rst_n(rst_n), .bus(ib));
  always #10 internal_clock = ~internal_clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else pass_cnt++;
  endtask
  task automatic start(input bit a, input bit b);
    if (a) ia.Tx_Enable = 1'b0;
    if (b) ib.Tx_Enable = 1'b0;
    @(negedge internal_clock);
    ia.Tx_Enable = 1'b1;
    ib.Tx_Enable = 1'b1;
  endtask
  task automatic watch(input int d, input logic [7:0] ba, input logic [7:0] bb, input bit ca, input bit cb);
    logic [9:0] fa, fb;
    int done_a, done_b, at_a, at_b;
    fa = {1'b1, ba, 1'b0};
    fb = {1'b1, bb, 1'b0};
    done_a = 0; done_b = 0; at_a = -1; at_b = -1;
    for (int k = 0; k <= 10 * d + 3; k++) begin
      if (ca) begin
        if (k == 0) begin
          check("tx_a_start_line", ia.Tx_Serial, 1'b0);
          check("tx_a_start_active", ia.Tx_Active, 1'b1);
        end
        if (k == d - 1) check("tx_a_start_end", ia.Tx_Serial, 1'b0);
        if (k == d) check("tx_a_bit0_begin", ia.Tx_Serial, fa[1]);
        if (k % d == d / 2) begin
          check("tx_a_bit", ia.Tx_Serial, fa[k / d]);
          check("tx_a_active", ia.Tx_Active, 1'b1);
        end
        if (k == 10 * d) check("tx_a_active_at_done", ia.Tx_Active, 1'b0);
      end
      if (cb && k % d == d / 2) begin
        check("tx_b_bit", ib.Tx_Serial, fb[k / d]);
        check("tx_b_active", ib.Tx_Active, 1'b1);
      end
      if (ia.Tx_Done) begin done_a++; at_a = k; end
      if (ib.Tx_Done) begin done_b++; at_b = k; end
      @(negedge internal_clock);
    end
    if (ca) begin
      check("tx_a_done_count", done_a, 1);
      check("tx_a_done_at", at_a, 10 * d);
      check("tx_a_idle_line", ia.Tx_Serial, 1'b1);
    end
    if (cb) begin
      check("tx_b_done_count", done_b, 1);
      check("tx_b_done_at", at_b, 10 * d);
    end
  endtask
  task automatic bang(input logic [7:0] b, input logic stop, input int d);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    b_inj = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b_drv = f[i];
      repeat (d) @(negedge internal_clock);
    end
    b_drv = 1'b1;
    repeat (50) @(negedge internal_clock);
    b_inj = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    b_inj = 1'b0;
    b_drv = 1'b1;
    ia.baud_rate_select = 3'b100;
    ib.baud_rate_select = 3'b100;
    ia.Tx_Byte = 8'h00;
    ib.Tx_Byte = 8'h00;
    ia.Tx_Enable = 1'b1;
    ib.Tx_Enable = 1'b1;
    ia.RX_Enable = 1'b1;
    ib.RX_Enable = 1'b1;
    repeat (3) @(negedge internal_clock);
    check("rst_tx_serial", ia.Tx_Serial, 1'b1);
    check("rst_tx_active", ia.Tx_Active, 1'b0);
    check("rst_tx_done", ia.Tx_Done, 1'b0);
    check("rst_rx_byte", ib.Rx_Byte, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge internal_clock);
    ib.RX_Enable = 1'b0;
    ia.Tx_Byte = 8'hA5;
    start(1, 0);
    watch(5208, 8'hA5, 8'h00, 1, 0);
    check("loop_rx_b_a5", ib.Rx_Byte, 8'hA5);
    ia.baud_rate_select = 3'b000;
    ib.baud_rate_select = 3'b000;
    ia.RX_Enable = 1'b0;
    ia.Tx_Byte = 8'hAA;
    ib.Tx_Byte = 8'hBB;
    start(1, 1);
    watch(434, 8'hAA, 8'hBB, 1, 1);
    check("duplex_rx_a_bb", ia.Rx_Byte, 8'hBB);
    check("duplex_rx_b_aa", ib.Rx_Byte, 8'hAA);
    ib.RX_Enable = 1'b1;
    ia.Tx_Byte = 8'h55;
    start(1, 0);
    ia.Tx_Byte = 8'hFF;
    ia.baud_rate_select = 3'b100;
    watch(434, 8'h55, 8'h00, 1, 0);
    check("disabled_rx_b_hold", ib.Rx_Byte, 8'hAA);
    ia.baud_rate_select = 3'b000;
    ib.RX_Enable = 1'b0;
    b_inj = 1'b1;
    b_drv = 1'b0;
    repeat (100) @(negedge internal_clock);
    b_drv = 1'b1;
    repeat (1000) @(negedge internal_clock);
    b_inj = 1'b0;
    check("glitch_rx_b_hold", ib.Rx_Byte, 8'hAA);
    bang(8'h0F, 1'b0, 434);
    check("framing_rx_b_hold", ib.Rx_Byte, 8'hAA);
    ia.Tx_Byte = 8'hC3;
    start(1, 0);
    repeat (1000) @(negedge internal_clock);
    rst_n = 1'b0;
    #1;
    check("midrst_tx_serial", ia.Tx_Serial, 1'b1);
    check("midrst_tx_active", ia.Tx_Active, 1'b0);
    check("midrst_tx_done", ia.Tx_Done, 1'b0);
    check("midrst_rx_b", ib.Rx_Byte, 8'h00);
    check("midrst_rx_a", ia.Rx_Byte, 8'h00);
    repeat (2) @(negedge internal_clock);
    rst_n = 1'b1;
    @(negedge internal_clock);
    ia.Tx_Byte = 8'h96;
    start(1, 0);
    watch(434, 8'h96, 8'h00, 1, 0);
    check("after_rst_rx_b_96", ib.Rx_Byte, 8'h96);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
